flash_page_loader: RTL and testbench

Upstream command sequencer for `spi_control`. It accepts a byte stream (valid/ready) carrying a bitstream image and buffers it one 256-byte flash page at a time. For each page it issues a WRITE command with the page address, and it serves the page bytes on `data_in` as `spi_control` requests them through `addr_out`. It optionally issues a chip ERASE first, and it finishes by issuing END so the flash clock is released.

---
 rtl/flash_page_loader.sv | 158 +++++++++++++++
 tb/tb_flash_page_loader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_page_loader.sv
// Page-buffered bitstream loader: gathers a byte stream into 256-byte pages and
// drives spi_control with ERASE / WRITE / END commands.
package spi_pkg;
    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_READ  = 3'd1,
        CMD_WRITE = 3'd2,
        CMD_ERASE = 3'd3,
        CMD_END   = 3'd4
    } cmd_t;
endpackage

// state       | meaning
// IDLE        | waiting for start, cmd NOP
// ERASE_ISSUE | ERASE presented until spi_control goes busy
// ERASE_WAIT  | waiting for chip erase to finish
// FILL        | accepting stream bytes into the page buffer
// WRITE_ISSUE | WRITE presented until spi_control goes busy
// WRITE_WAIT  | spi_control pulling page bytes via addr_out
// END_ISSUE   | END presented until spi_control goes busy
// DONE        | image written, END held
// ERR         | capacity overflow, END held
module flash_page_loader #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          MAX_PAGES   = 4096,
    parameter bit          ERASE_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output spi_pkg::cmd_t cmd,
    input  logic          cmd_done,
    output logic [23:0]   addr_in,
    input  logic [23:0]   addr_out,
    output logic [7:0]    data_in,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [15:0]   pages_written
);
    import spi_pkg::*;

    typedef enum logic [3:0] {
        IDLE, ERASE_ISSUE, ERASE_WAIT, FILL, WRITE_ISSUE, WRITE_WAIT,
        END_ISSUE, DONE, ERR
    } state_t;

    localparam logic [15:0] LAST_PAGE = 16'(MAX_PAGES - 1);

    state_t      state_q, state_d;
    logic [15:0] page_idx_q, page_idx_d;
    logic [8:0]  fill_q, fill_d;
    logic        last_q, last_d;
    logic [15:0] pages_written_d;
    logic [23:0] addr_d;
    logic        buf_we;
    logic [7:0]  page_buf [256];
    logic [7:0]  rd_idx;
    logic        unused_addr_hi;

    function automatic cmd_t cmd_for(input state_t s);
        case (s)
            ERASE_ISSUE:           cmd_for = CMD_ERASE;
            WRITE_ISSUE:           cmd_for = CMD_WRITE;
            END_ISSUE, DONE, ERR:  cmd_for = CMD_END;
            default:               cmd_for = CMD_NOP;
        endcase
    endfunction

    assign s_ready        = (state_q == FILL);
    assign rd_idx         = addr_out[7:0];
    assign unused_addr_hi = ^addr_out[23:8];
    // bytes past the fill level read as erased flash so a short page pads with FF
    assign data_in        = ({1'b0, rd_idx} < fill_q) ? page_buf[rd_idx] : 8'hFF;
    assign addr_d         = BASE_ADDR + {page_idx_d, 8'h00};

    always_comb begin
        state_d         = state_q;
        page_idx_d      = page_idx_q;
        fill_d          = fill_q;
        last_d          = last_q;
        pages_written_d = pages_written;
        buf_we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ERASE_FIRST ? ERASE_ISSUE : FILL;
                    page_idx_d = '0;
                    fill_d     = '0;
                    last_d     = 1'b0;
                end
            end
            ERASE_ISSUE: if (!cmd_done) state_d = ERASE_WAIT;
            ERASE_WAIT:  if (cmd_done)  state_d = FILL;
            FILL: begin
                if (s_valid) begin
                    buf_we = 1'b1;
                    fill_d = fill_q + 9'd1;
                    last_d = s_last;
                    if (s_last || fill_q == 9'd255) state_d = WRITE_ISSUE;
                end
            end
            WRITE_ISSUE: if (!cmd_done) state_d = WRITE_WAIT;
            WRITE_WAIT: begin
                if (cmd_done) begin
                    pages_written_d = pages_written + 16'd1;
                    if (last_q) begin
                        state_d = END_ISSUE;
                    end else if (page_idx_q == LAST_PAGE) begin
                        state_d = ERR;
                    end else begin
                        page_idx_d = page_idx_q + 16'd1;
                        fill_d     = '0;
                        state_d    = FILL;
                    end
                end
            end
            END_ISSUE: if (!cmd_done) state_d = DONE;
            DONE:      state_d = DONE;
            ERR:       state_d = ERR;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            page_idx_q    <= '0;
            fill_q        <= '0;
            last_q        <= 1'b0;
            pages_written <= '0;
            cmd           <= CMD_NOP;
            addr_in       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            page_idx_q    <= page_idx_d;
            fill_q        <= fill_d;
            last_q        <= last_d;
            pages_written <= pages_written_d;
            cmd           <= cmd_for(state_d);
            if (state_d == WRITE_ISSUE) addr_in <= addr_d;
            busy          <= !(state_d == IDLE || state_d == DONE || state_d == ERR);
            done          <= (state_d == DONE);
            error         <= (state_d == ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) page_buf[fill_q[7:0]] <= s_data;
    end
endmodule

// File: tb/tb_flash_page_loader.sv
// Bench for flash_page_loader: three parameterisations share a behavioural
// spi_control model; page bytes are checked against a queue filled by the stream driver.
module tb_flash_page_loader;
    import spi_pkg::*;

    typedef struct packed {
        cmd_t        c;
        logic [23:0] a;
    } exp_cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [3];
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        cmd_done;
    logic [23:0] addr_out;

    logic        s_ready_v [3];
    cmd_t        cmd_v [3];
    logic [23:0] addr_in_v [3];
    logic [7:0]  data_in_v [3];
    logic        busy_v [3];
    logic        done_v [3];
    logic        error_v [3];
    logic [15:0] pw_v [3];

    logic [1:0]  sel = 2'd0;
    logic        s_ready_m, busy_m, done_m, error_m;
    cmd_t        cmd_m;
    logic [23:0] addr_in_m;
    logic [7:0]  data_in_m;
    logic [15:0] pw_m;

    assign s_ready_m = s_ready_v[sel];
    assign cmd_m     = cmd_v[sel];
    assign addr_in_m = addr_in_v[sel];
    assign data_in_m = data_in_v[sel];
    assign busy_m    = busy_v[sel];
    assign done_m    = done_v[sel];
    assign error_m   = error_v[sel];
    assign pw_m      = pw_v[sel];

    int n_vec = 0;
    int n_err = 0;
    int sready_viol = 0;
    logic wr_active = 1'b0;
    exp_cmd_t   exp_cmd [$];
    logic [7:0] exp_byte [$];

    always #5 clk = ~clk;

    flash_page_loader u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready_v[0]), .cmd(cmd_v[0]), .cmd_done(cmd_done),
        .addr_in(addr_in_v[0]), .addr_out(addr_out), .data_in(data_in_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0]), .pages_written(pw_v[0]));

    flash_page_loader #(.MAX_PAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready_v[1]), .cmd(cmd_v[1]), .cmd_done(cmd_done),
        .addr_in(addr_in_v[1]), .addr_out(addr_out), .data_in(data_in_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1]), .pages_written(pw_v[1]));

    flash_page_loader #(.BASE_ADDR(24'h010000), .ERASE_FIRST(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .s_data(s_data), .s_valid(s_valid),
        .s_last(s_last), .s_ready(s_ready_v[2]), .cmd(cmd_v[2]), .cmd_done(cmd_done),
        .addr_in(addr_in_v[2]), .addr_out(addr_out), .data_in(data_in_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .error(error_v[2]), .pages_written(pw_v[2]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // spi_control stand-in: acts on falling edges, walks addr_out 0..255 for WRITE
    initial begin
        exp_cmd_t   e;
        cmd_t       served;
        logic [8:0] exp9;
        cmd_done = 1'b1;
        addr_out = '0;
        served   = CMD_NOP;
        forever begin
            @(negedge clk);
            if (rst || cmd_m == CMD_NOP) begin
                served   = CMD_NOP;
                cmd_done = 1'b1;
            end else if (cmd_m != served) begin
                served = cmd_m;
                if (exp_cmd.size() > 0) e = exp_cmd.pop_front();
                else begin
                    e.c = CMD_READ;
                    e.a = 24'hFFFFFF;
                end
                check_val("cmd_seq", 32'(cmd_m), 32'(e.c));
                if (cmd_m == CMD_WRITE) check_val("wr_addr", 32'(addr_in_m), 32'(e.a));
                cmd_done = 1'b0;
                if (cmd_m == CMD_WRITE) begin
                    wr_active = 1'b1;
                    for (int i = 0; i < 256 && !rst; i++) begin
                        addr_out = (24'($urandom) & 24'hFFFF00) | 24'(i);
                        #1;
                        if (exp_byte.size() > 0) exp9 = {1'b0, exp_byte.pop_front()};
                        else exp9 = 9'h100;
                        check_val("page_byte", 32'({1'b0, data_in_m}), 32'(exp9));
                        @(negedge clk);
                    end
                    wr_active = 1'b0;
                end else begin
                    for (int k = 0; k < 3 && !rst; k++) @(negedge clk);
                end
                cmd_done = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (wr_active && s_ready_m) sready_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    task automatic push_cmd(input cmd_t c, input logic [23:0] a);
        exp_cmd_t e;
        e.c = c;
        e.a = a;
        exp_cmd.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        exp_cmd.delete();
        exp_byte.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk) start_v[sel] = 1'b1;
        @(negedge clk) start_v[sel] = 1'b0;
    endtask

    task automatic send_stream(input int n, input bit with_last, input int gap_pct,
                               input int mul, input int add, output int acc);
        int  i;
        int  cyc;
        int  budget;
        logic rdy;
        i = 0; cyc = 0; acc = 0;
        budget = n * 4 + 1000;
        while (i < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = 8'($urandom);
                continue;
            end
            s_valid = 1'b1;
            s_data  = 8'(i * mul + add);
            s_last  = with_last && (i == n - 1);
            rdy     = s_ready_m;
            @(posedge clk);
            if (rdy) begin
                exp_byte.push_back(s_data);
                i++;
                acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (with_last && acc == n && (n % 256) != 0)
            for (int k = n % 256; k < 256; k++) exp_byte.push_back(8'hFF);
    endtask

    task automatic wait_term();
        int c;
        for (c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (done_m || error_m) break;
        end
        check_val("term_reached", 32'(done_m | error_m), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic run_image(input int n, input bit with_last, input int gap, input int mul,
                             input int add, input logic [23:0] base, input bit erase,
                             input int exp_pages, input bit exp_err);
        int acc;
        if (erase) push_cmd(CMD_ERASE, 24'h0);
        for (int p = 0; p < exp_pages; p++) push_cmd(CMD_WRITE, base + 24'(p * 256));
        push_cmd(CMD_END, 24'h0);
        pulse_start();
        if (erase) check_val("start_lat_cmd", 32'(cmd_m), 32'(CMD_ERASE));
        else begin
            check_val("start_lat_rdy", 32'(s_ready_m), 32'd1);
            check_val("start_lat_cmd", 32'(cmd_m), 32'(CMD_NOP));
        end
        send_stream(n, with_last, gap, mul, add, acc);
        check_val("accepted", 32'(acc), exp_err ? 32'(exp_pages * 256) : 32'(n));
        wait_term();
        check_val("done", 32'(done_m), exp_err ? 32'd0 : 32'd1);
        check_val("error", 32'(error_m), 32'(exp_err));
        check_val("busy_end", 32'(busy_m), 32'd0);
        check_val("cmd_end", 32'(cmd_m), 32'(CMD_END));
        check_val("pages_written", 32'(pw_m), 32'(exp_pages));
        check_val("s_ready_end", 32'(s_ready_m), 32'd0);
        check_val("cmd_q_left", 32'(exp_cmd.size()), 32'd0);
        check_val("byte_q_left", 32'(exp_byte.size()), 32'd0);
        check_val("sready_in_write", 32'(sready_viol), 32'd0);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) start_v[j] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("rst_cmd", 32'(cmd_m), 32'(CMD_NOP));
        check_val("rst_addr_in", 32'(addr_in_m), 32'd0);
        check_val("rst_s_ready", 32'(s_ready_m), 32'd0);
        check_val("rst_busy", 32'(busy_m), 32'd0);
        check_val("rst_done", 32'(done_m), 32'd0);
        check_val("rst_error", 32'(error_m), 32'd0);
        check_val("rst_pw", 32'(pw_m), 32'd0);
        check_val("rst_data_in", 32'(data_in_m), 32'hFF);

        sel = 2'd0;
        run_image(256, 1'b1, 0, 1, 0, 24'h0, 1'b1, 1, 1'b0);
        do_reset();
        run_image(300, 1'b1, 0, 1, 0, 24'h0, 1'b1, 2, 1'b0);
        do_reset();
        run_image(520, 1'b1, 40, 13, 5, 24'h0, 1'b1, 3, 1'b0);

        do_reset();
        sel = 2'd1;
        run_image(600, 1'b0, 0, 1, 0, 24'h0, 1'b1, 2, 1'b1);

        do_reset();
        sel = 2'd2;
        run_image(100, 1'b1, 0, 7, 3, 24'h010000, 1'b0, 1, 1'b0);

        do_reset();
        sel = 2'd0;
        begin
            int acc;
            int c;
            push_cmd(CMD_ERASE, 24'h0);
            push_cmd(CMD_WRITE, 24'h000000);
            push_cmd(CMD_WRITE, 24'h000100);
            push_cmd(CMD_END, 24'h0);
            pulse_start();
            send_stream(300, 1'b1, 0, 1, 0, acc);
            for (c = 0; c < 2000; c++) begin
                @(negedge clk);
                if (pw_m == 16'd1 && wr_active) break;
            end
            repeat (4) @(negedge clk);
            check_val("pre_rst_pw", 32'(pw_m), 32'd1);
            check_val("pre_rst_busy", 32'(busy_m), 32'd1);
            @(posedge clk); #2 rst = 1'b1;
            @(posedge clk); #1;
            check_val("mid_rst_cmd", 32'(cmd_m), 32'(CMD_NOP));
            check_val("mid_rst_busy", 32'(busy_m), 32'd0);
            check_val("mid_rst_pw", 32'(pw_m), 32'd0);
            @(posedge clk); #2 rst = 1'b0;
            exp_cmd.delete();
            exp_byte.delete();
        end
        run_image(256, 1'b1, 0, 3, 1, 24'h0, 1'b1, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
